// File: rtl/ex_muldiv.sv
// RV32 execute stage: single-cycle ALU/branch/jump/LUI/AUIPC plus RV32M with a
// pipelined multiplier and a restoring divider that stall the core via hold_flag_o.
module ex_muldiv #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] inst_addr_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            rd_wen_i,
  input  logic            flush_i,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_wen_o,
  output logic [XLEN-1:0] jump_addr_o,
  output logic            jump_en_o,
  output logic            hold_flag_o,
  output logic            busy_o
);
  localparam int SHW = $clog2(XLEN);
  localparam int PW  = 2*XLEN+2;
  localparam int CW  = $clog2(XLEN+1);

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       is_mop;
  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];
  assign is_mop = (opcode == OP_REG) && (funct7 == 7'b0000001);

  logic [XLEN-1:0] imm_b, imm_j, imm_u;
  assign imm_b = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
  assign imm_j = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));
  assign imm_u = XLEN'($signed({inst_i[31:12], 12'b0}));

  // ---------------- single-cycle path ----------------
  logic            lt_s, lt_u, br_take, alu_ok;
  logic [XLEN-1:0] sum, pc4, sra_res, srl_res, sll_res, alu_base, alu_data;
  logic [XLEN-1:0] alu_jaddr;
  logic            alu_jen;

  assign lt_s    = $signed(op1_i) < $signed(op2_i);
  assign lt_u    = op1_i < op2_i;
  assign sum     = op1_i + op2_i;
  assign pc4     = inst_addr_i + XLEN'(4);
  assign sra_res = XLEN'($signed(op1_i) >>> op2_i[SHW-1:0]);
  assign srl_res = op1_i >> op2_i[SHW-1:0];
  assign sll_res = op1_i << op2_i[SHW-1:0];

  always_comb begin
    alu_base = '0;
    case (funct3)
      3'b000:  alu_base = (opcode == OP_REG && inst_i[30]) ? op1_i - op2_i : sum;
      3'b001:  alu_base = sll_res;
      3'b010:  alu_base = XLEN'(lt_s);
      3'b011:  alu_base = XLEN'(lt_u);
      3'b100:  alu_base = op1_i ^ op2_i;
      3'b101:  alu_base = inst_i[30] ? sra_res : srl_res;
      3'b110:  alu_base = op1_i | op2_i;
      default: alu_base = op1_i & op2_i;
    endcase
  end

  always_comb begin
    br_take = 1'b0;
    case (funct3)
      3'b000:  br_take = (op1_i == op2_i);
      3'b001:  br_take = (op1_i != op2_i);
      3'b100:  br_take = lt_s;
      3'b101:  br_take = !lt_s;
      3'b110:  br_take = lt_u;
      3'b111:  br_take = !lt_u;
      default: br_take = 1'b0;
    endcase
  end

  always_comb begin
    alu_ok    = 1'b0;
    alu_data  = '0;
    alu_jen   = 1'b0;
    alu_jaddr = '0;
    case (opcode)
      OP_IMM: begin
        alu_ok   = 1'b1;
        alu_data = alu_base;
      end
      OP_REG: begin
        if (funct7 == 7'b0000000 ||
            (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          alu_ok   = 1'b1;
          alu_data = alu_base;
        end
      end
      OP_BR: begin
        alu_jen   = br_take;
        alu_jaddr = br_take ? inst_addr_i + imm_b : '0;
      end
      OP_JAL: begin
        alu_ok    = 1'b1;
        alu_data  = pc4;
        alu_jen   = 1'b1;
        alu_jaddr = inst_addr_i + imm_j;
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          alu_ok    = 1'b1;
          alu_data  = pc4;
          alu_jen   = 1'b1;
          alu_jaddr = {sum[XLEN-1:1], 1'b0};
        end
      end
      OP_LUI: begin
        alu_ok   = 1'b1;
        alu_data = imm_u;
      end
      OP_AUIPC: begin
        alu_ok   = 1'b1;
        alu_data = inst_addr_i + imm_u;
      end
      default: ;
    endcase
  end

  // ---------------- M extension state ----------------
  state_e            state_q, state_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic [2:0]        f3_q, f3_d;
  logic [4:0]        rd_q, rd_d;
  logic              wen_q, wen_d;
  logic [MUL_LAT-1:0] mul_vld_q, mul_vld_d;
  logic [XLEN-1:0]   quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d, spec_res_q, spec_res_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_q, neg_d, dsgn_q, dsgn_d, spec_q, spec_d;

  logic            issue, mul_in, dsgn, dz, ovf, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag, sub;
  logic [XLEN:0]   trial;
  logic            ge;

  assign issue  = (state_q == IDLE) && is_mop;
  assign mul_in = issue && !funct3[2];
  assign dsgn   = !funct3[0];
  assign a_neg  = dsgn && op1_i[XLEN-1];
  assign b_neg  = dsgn && op2_i[XLEN-1];
  assign a_mag  = a_neg ? -op1_i : op1_i;
  assign b_mag  = b_neg ? -op2_i : op2_i;
  assign dz     = (op2_i == '0);
  assign ovf    = dsgn && (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (op2_i == '1);

  // One restoring step: shift the next dividend bit into the partial remainder.
  assign trial = {rem_q, quo_q[XLEN-1]};
  assign ge    = trial >= {1'b0, dvs_q};
  assign sub   = trial[XLEN-1:0] - dvs_q;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    f3_d       = f3_q;
    rd_d       = rd_q;
    wen_d      = wen_q;
    mul_vld_d  = MUL_LAT'({mul_vld_q, mul_in});
    quo_d      = quo_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    dsgn_d     = dsgn_q;
    spec_d     = spec_q;
    spec_res_d = spec_res_q;
    case (state_q)
      IDLE: begin
        if (is_mop) begin
          a_d   = op1_i;
          b_d   = op2_i;
          f3_d  = funct3;
          rd_d  = rd_addr_i;
          wen_d = rd_wen_i && (rd_addr_i != 5'd0);
          if (!funct3[2]) begin
            state_d = mul_vld_d[MUL_LAT-1] ? DONE : MUL;
          end else begin
            quo_d      = a_mag;
            rem_d      = '0;
            dvs_d      = b_mag;
            cnt_d      = '0;
            neg_d      = a_neg ^ b_neg;
            dsgn_d     = a_neg;
            spec_d     = dz || ovf;
            spec_res_d = dz ? (funct3[1] ? op1_i : '1) : (funct3[1] ? '0 : op1_i);
            state_d    = (dz || ovf) ? DONE : DIV;
          end
        end
      end
      MUL: if (mul_vld_d[MUL_LAT-1]) state_d = DONE;
      DIV: begin
        rem_d = ge ? sub : trial[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], ge};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN-1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i && state_q != IDLE) begin
      state_d   = IDLE;
      mul_vld_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      f3_q       <= '0;
      rd_q       <= '0;
      wen_q      <= 1'b0;
      mul_vld_q  <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      dsgn_q     <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      f3_q       <= f3_d;
      rd_q       <= rd_d;
      wen_q      <= wen_d;
      mul_vld_q  <= mul_vld_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dvs_q      <= dvs_d;
      cnt_q      <= cnt_d;
      neg_q      <= neg_d;
      dsgn_q     <= dsgn_d;
      spec_q     <= spec_d;
      spec_res_q <= spec_res_d;
    end
  end

  // ---------------- multiplier ----------------
  logic signed [XLEN:0]   ma, mb;
  logic signed [PW-1:0]   prod0;
  logic [2*XLEN-1:0]      prod;
  logic                   unused_prod;

  assign ma    = {(f3_q[0] ^ f3_q[1]) & a_q[XLEN-1], a_q};
  assign mb    = {(f3_q[0] & !f3_q[1]) & b_q[XLEN-1], b_q};
  assign prod0 = PW'(ma) * PW'(mb);
  assign unused_prod = ^prod0[PW-1:2*XLEN];

  generate
    if (MUL_LAT > 1) begin : g_pipe
      logic [2*XLEN-1:0] pipe_d [MUL_LAT-1];
      logic [2*XLEN-1:0] pipe_q [MUL_LAT-1];
      always_comb begin
        pipe_d[0] = prod0[2*XLEN-1:0];
        for (int i = 1; i < MUL_LAT-1; i++) pipe_d[i] = pipe_q[i-1];
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < MUL_LAT-1; i++) pipe_q[i] <= '0;
        end else begin
          for (int i = 0; i < MUL_LAT-1; i++) pipe_q[i] <= pipe_d[i];
        end
      end
      assign prod = pipe_q[MUL_LAT-2];
    end else begin : g_nopipe
      assign prod = prod0[2*XLEN-1:0];
    end
  endgenerate

  // ---------------- writeback mux ----------------
  logic [XLEN-1:0] mul_res, div_res, m_res;
  assign mul_res = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  assign div_res = spec_q   ? spec_res_q :
                   f3_q[1]  ? (dsgn_q ? -rem_q : rem_q) :
                              (neg_q  ? -quo_q : quo_q);
  assign m_res   = mul_vld_q[MUL_LAT-1] ? mul_res : div_res;

  always_comb begin
    rd_addr_o   = '0;
    rd_data_o   = '0;
    rd_wen_o    = 1'b0;
    jump_addr_o = '0;
    jump_en_o   = 1'b0;
    hold_flag_o = 1'b0;
    busy_o      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (is_mop) begin
          hold_flag_o = 1'b1;
        end else begin
          rd_addr_o   = alu_ok ? rd_addr_i : 5'd0;
          rd_data_o   = alu_data;
          rd_wen_o    = alu_ok && rd_wen_i;
          jump_addr_o = alu_jaddr;
          jump_en_o   = alu_jen;
        end
      end
      MUL, DIV: hold_flag_o = !flush_i;
      default: begin
        if (!flush_i) begin
          rd_addr_o = rd_q;
          rd_data_o = m_res;
          rd_wen_o  = wen_q;
        end
      end
    endcase
    // Outputs are forced low for the whole time reset is held.
    if (!rst_n) begin
      rd_addr_o   = '0;
      rd_data_o   = '0;
      rd_wen_o    = 1'b0;
      jump_addr_o = '0;
      jump_en_o   = 1'b0;
      hold_flag_o = 1'b0;
      busy_o      = 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed and randomized bench for ex_muldiv against an arithmetic reference model.
module tb_ex_muldiv;
  localparam int XLEN    = 32;
  localparam int MUL_LAT = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [31:0]     inst = '0;
  logic [XLEN-1:0] pc = '0, op1 = '0, op2 = '0;
  logic [4:0]      rd_addr = '0;
  logic            rd_wen = 1'b0, flush = 1'b0;
  logic [4:0]      rd_addr_o;
  logic [XLEN-1:0] rd_data_o, jump_addr_o;
  logic            rd_wen_o, jump_en_o, hold_flag_o, busy_o;

  int checks = 0;
  int errors = 0;

  ex_muldiv #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .inst_i(inst), .inst_addr_i(pc), .op1_i(op1), .op2_i(op2),
    .rd_addr_i(rd_addr), .rd_wen_i(rd_wen), .flush_i(flush),
    .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .rd_wen_o(rd_wen_o),
    .jump_addr_o(jump_addr_o), .jump_en_o(jump_en_o),
    .hold_flag_o(hold_flag_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_inst(input logic [2:0] f3, input logic [4:0] rd);
    return {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction

  // Reference: RV32M semantics from plain 64-bit arithmetic and SV integer division.
  function automatic logic [31:0] m_ref(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] p, sa, sb, ua, ub;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    ia = a;
    ib = b;
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int m_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return MUL_LAT;
    if (b == 0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  // Issue one M op and follow it to its writeback cycle; returns positioned in DONE.
  task automatic run_m(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic wen);
    int n;
    bit early;
    @(negedge clk);
    inst = m_inst(f3, rd); op1 = a; op2 = b; rd_addr = rd; rd_wen = wen;
    #1;
    chk({tag, " hold@T"}, {31'b0, hold_flag_o}, 32'd1);
    n = 0;
    early = 1'b0;
    while (hold_flag_o === 1'b1 && n < 100) begin
      if (rd_wen_o !== 1'b0 || jump_en_o !== 1'b0) early = 1'b1;
      @(negedge clk); #1;
      n++;
    end
    chk({tag, " latency"}, n, m_lat(f3, a, b));
    chk({tag, " quiet"}, {31'b0, early}, 32'd0);
    chk({tag, " data"}, rd_data_o, m_ref(f3, a, b));
    chk({tag, " wen"}, {31'b0, rd_wen_o}, {31'b0, wen && rd != 0});
    chk({tag, " addr"}, {27'b0, rd_addr_o}, {27'b0, rd});
  endtask

  task automatic idle_nop(input string tag);
    @(negedge clk);
    inst = '0; rd_wen = 1'b0; flush = 1'b0;
    #1;
    chk({tag, " busy"}, {31'b0, busy_o}, 32'd0);
    chk({tag, " no wb"}, {31'b0, rd_wen_o}, 32'd0);
  endtask

  task automatic alu(input string tag, input logic [31:0] i, input logic [31:0] p,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] ed,
                     input logic ew, input logic ej, input logic [31:0] ea);
    @(negedge clk);
    inst = i; pc = p; op1 = a; op2 = b; rd_addr = i[11:7]; rd_wen = 1'b1;
    #1;
    chk({tag, " data"}, rd_data_o, ed);
    chk({tag, " wen"}, {31'b0, rd_wen_o}, {31'b0, ew});
    chk({tag, " jen"}, {31'b0, jump_en_o}, {31'b0, ej});
    chk({tag, " jaddr"}, jump_addr_o, ea);
    chk({tag, " hold"}, {31'b0, hold_flag_o}, 32'd0);
  endtask

  initial begin
    logic [31:0] a, b, e, ins;
    logic [2:0]  f3;
    logic [6:0]  f7;
    bit          bad;

    // Reset: outputs low even with a live instruction on the input.
    inst = {12'd2, 5'd0, 3'b000, 5'd1, 7'b0010011}; op1 = 1; op2 = 2; rd_addr = 1; rd_wen = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset data", rd_data_o, 0);
    chk("reset wen", {31'b0, rd_wen_o}, 0);
    chk("reset busy", {31'b0, busy_o}, 0);
    chk("reset hold", {31'b0, hold_flag_o}, 0);
    @(negedge clk); rst_n = 1'b1;

    // Single-cycle regression.
    alu("ADDI", {12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011}, 0, 0, 5, 5, 1, 0, 0);
    alu("SLTI", {12'd0, 5'd1, 3'b010, 5'd2, 7'b0010011}, 0, 32'hFFFF_FFFF, 0, 1, 1, 0, 0);
    alu("SRAI", {7'b0100000, 5'd4, 5'd1, 3'b101, 5'd3, 7'b0010011}, 0, 32'h8000_0000,
        32'h404, 32'hF800_0000, 1, 0, 0);
    alu("BEQ t", {1'b0, 6'd0, 5'd2, 5'd1, 3'b000, 4'b0100, 1'b0, 7'b1100011}, 32'h100, 7, 7,
        0, 0, 1, 32'h108);
    alu("BEQ nt", {1'b0, 6'd0, 5'd2, 5'd1, 3'b000, 4'b0100, 1'b0, 7'b1100011}, 32'h100, 7, 8,
        0, 0, 0, 0);
    alu("JALR", {12'd0, 5'd1, 3'b000, 5'd1, 7'b1100111}, 32'h100, 32'h201, 0, 32'h104, 1, 1,
        32'h200);
    alu("unknown", {25'h1ABCDEF, 7'b0001011}, 32'h100, 5, 6, 0, 0, 0, 0);
    // flush in IDLE is ignored for single-cycle ops
    flush = 1'b1;
    alu("ADD flushIDLE", {7'b0, 5'd2, 5'd1, 3'b000, 5'd4, 7'b0110011}, 0, 3, 4, 7, 1, 0, 0);
    flush = 1'b0;

    for (int k = 0; k < 8; k++) begin
      a = $urandom; b = $urandom;
      f7 = 7'b0;
      case (k % 6)
        0: begin f3 = 3'b000; e = a + b; end
        1: begin f3 = 3'b000; f7 = 7'b0100000; e = a - b; end
        2: begin f3 = 3'b100; e = a ^ b; end
        3: begin f3 = 3'b011; e = (a < b) ? 1 : 0; end
        4: begin f3 = 3'b010; e = ($signed(a) < $signed(b)) ? 1 : 0; end
        default: begin f3 = 3'b111; e = a & b; end
      endcase
      ins = {f7, 5'd2, 5'd1, f3, 5'd9, 7'b0110011};
      alu($sformatf("rand R%0d", k), ins, 0, a, b, e, 1, 0, 0);
    end

    // Directed M ops.
    run_m("MUL", 3'd0, 32'hFFFF_FFFF, 2, 5'd3, 1);
    run_m("MULHU", 3'd3, 32'hFFFF_FFFF, 2, 5'd3, 1);
    run_m("MULH", 3'd1, 32'hFFFF_FFFF, 2, 5'd3, 1);
    run_m("DIV", 3'd4, -32'sd7, 2, 5'd4, 1);
    run_m("REM", 3'd6, -32'sd7, 2, 5'd4, 1);
    run_m("DIVU", 3'd5, 7, 2, 5'd4, 1);
    run_m("DIVU/0", 3'd5, 100, 0, 5'd5, 1);
    run_m("REM/0", 3'd6, 100, 0, 5'd5, 1);
    run_m("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 1);
    run_m("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 1);
    idle_nop("after ovf");
    run_m("MULHSU nowen", 3'd2, 32'h8000_0001, 32'hFFFF_FFFF, 5'd7, 0);
    run_m("DIV x0", 3'd4, 1000, 7, 5'd0, 1);
    idle_nop("after x0");

    // Back-to-back MULs: second issue right after the first DONE.
    run_m("b2b MUL1", 3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd8, 1);
    run_m("b2b MUL2", 3'd1, 32'h8765_4321, 32'h0FED_CBA9, 5'd9, 1);
    idle_nop("after b2b");

    // Flush of a DIV at T+5.
    @(negedge clk);
    inst = m_inst(3'd4, 5'd10); op1 = 12345; op2 = 17; rd_addr = 10; rd_wen = 1;
    repeat (5) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush hold", {31'b0, hold_flag_o}, 0);
    chk("flush wen", {31'b0, rd_wen_o}, 0);
    @(negedge clk);
    flush = 1'b0; inst = '0; rd_wen = 1'b0;
    #1;
    chk("flush busy", {31'b0, busy_o}, 0);
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk); #1;
      if (rd_wen_o !== 1'b0 || busy_o !== 1'b0) bad = 1'b1;
    end
    chk("flush quiet", {31'b0, bad}, 0);

    // Reset in the middle of a DIV.
    @(negedge clk);
    inst = m_inst(3'd4, 5'd5); op1 = -32'sd7; op2 = 2; rd_addr = 5; rd_wen = 1;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst data", rd_data_o, 0);
    chk("midrst hold", {31'b0, hold_flag_o}, 0);
    chk("midrst busy", {31'b0, busy_o}, 0);
    chk("midrst wen", {31'b0, rd_wen_o}, 0);
    @(negedge clk);
    rst_n = 1'b1; inst = {12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011}; op1 = 0; op2 = 5; rd_addr = 1;
    #1;
    chk("postrst busy", {31'b0, busy_o}, 0);
    chk("postrst ADDI", rd_data_o, 5);
    chk("postrst wen", {31'b0, rd_wen_o}, 1);
    @(negedge clk);
    inst = '0; rd_wen = 1'b0;
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk); #1;
      if (rd_wen_o !== 1'b0 || busy_o !== 1'b0) bad = 1'b1;
    end
    chk("postrst quiet", {31'b0, bad}, 0);

    // Randomized M ops.
    for (int k = 0; k < 16; k++) begin
      f3 = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = $urandom_range(1, 15);
        2: b = 0;
        default: b = -($urandom_range(1, 9));
      endcase
      run_m($sformatf("rand M%0d f3=%0d", k, f3), f3, a, b, 5'($urandom_range(1, 31)), 1);
    end
    idle_nop("end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
